// File: rtl/vending_machine_param.sv
// -----------------------------------------------------------------------------
// vending_machine_param
//   Vending controller with a configurable price and credit width. It sits
//   between the debounced coin acceptor and the dispenser and change-hopper
//   drivers.
//
//   - Credit is kept in half-units: a half coin adds 1 and a one coin adds 2.
//   - The controller vends once credit reaches PRICE.
//   - Change and cancelled credit are paid back as serial half-unit pulses.
//   - Coins that arrive while a payout is in progress are rejected.
//
// Optional feature (define STOCK_COUNT_EN):
//   Adds a stock counter. It is loaded with STOCK_INIT at reset and on
//   pi_restock, and it drops by one on each vend. While stock is zero, every
//   coin is rejected. Without the macro, stock is unlimited, po_sold_out is
//   tied to 0, pi_restock is ignored and no stock register exists.
//
// Ports:
//   sys_clk        in   1      system clock, rising edge
//   sys_rst_n      in   1      asynchronous active-low reset
//   pi_money_half  in   1      half coin pulse (1 unit)
//   pi_money_one   in   1      one coin pulse (2 units)
//   pi_cancel      in   1      refund the current credit
//   pi_restock     in   1      reload stock (STOCK_COUNT_EN only)
//   po_beverage    out  1      dispense pulse
//   po_money       out  1      one pulse per half-unit returned
//   po_reject      out  1      the coin sampled on the last edge is returned
//   po_credit      out  CNT_W  accumulated credit
//   po_busy        out  1      high while change or a refund is being paid
//   po_sold_out    out  1      stock is empty
// -----------------------------------------------------------------------------
module vending_machine_param #(
  parameter int PRICE      = 3,
  parameter int CNT_W      = 4,
  parameter int STOCK_INIT = 8,
  parameter int STOCK_W    = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pi_money_half,
  input  logic             pi_money_one,
  input  logic             pi_cancel,
  input  logic             pi_restock,
  output logic             po_beverage,
  output logic             po_money,
  output logic             po_reject,
  output logic [CNT_W-1:0] po_credit,
  output logic             po_busy,
  output logic             po_sold_out
);

  localparam logic [CNT_W:0] PRICE_X = (CNT_W+1)'(PRICE);

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_CHANGE,
    ST_REFUND
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] ret_cnt;

  logic             coin_any;
  logic             coin_bad;
  logic             sold_out_now;
  logic             cancel_go;
  logic             vend_go;
  logic [1:0]       coin;
  // One bit wider than the credit so that credit + coin can never wrap,
  // even before the vend comparison clears it.
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   change;

  assign coin_any = pi_money_half | pi_money_one;
  assign coin_bad = pi_money_half & pi_money_one;

  // Coin value in half-units. An invalid pair, or any coin while sold out,
  // counts as nothing.
  always_comb begin
    coin = 2'd0;
    if (!coin_bad && !sold_out_now) begin
      if (pi_money_half) begin
        coin = 2'd1;
      end else if (pi_money_one) begin
        coin = 2'd2;
      end
    end
  end

  assign sum    = {1'b0, po_credit} + {{(CNT_W-1){1'b0}}, coin};
  assign change = sum - PRICE_X;

  // A cancel takes priority over a vend, even when the coin arriving with it
  // would have reached the price.
  assign cancel_go = (state == ST_ACCEPT) && pi_cancel && (sum != '0);
  assign vend_go   = (state == ST_ACCEPT) && !pi_cancel && (sum >= PRICE_X);

`ifdef STOCK_COUNT_EN
  logic [STOCK_W-1:0] stock;
  logic [STOCK_W-1:0] stock_nxt;

  assign sold_out_now = (stock == '0);

  // A restock load wins over the decrement of a vend on the same edge.
  always_comb begin
    stock_nxt = stock;
    if (pi_restock) begin
      stock_nxt = STOCK_W'(STOCK_INIT);
    end else if (vend_go) begin
      stock_nxt = stock - STOCK_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stock       <= STOCK_W'(STOCK_INIT);
      po_sold_out <= 1'b0;
    end else begin
      stock       <= stock_nxt;
      po_sold_out <= (stock_nxt == '0);
    end
  end
`else
  logic [STOCK_W-1:0] unused_stock_cfg;
  assign unused_stock_cfg = STOCK_W'(STOCK_INIT) ^ {{(STOCK_W-1){1'b0}}, pi_restock};
  assign sold_out_now     = 1'b0;
  assign po_sold_out      = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_ACCEPT;
      ret_cnt     <= '0;
      po_credit   <= '0;
      po_beverage <= 1'b0;
      po_money    <= 1'b0;
      po_reject   <= 1'b0;
      po_busy     <= 1'b0;
    end else begin
      po_beverage <= 1'b0;
      po_money    <= 1'b0;
      po_reject   <= 1'b0;
      case (state)
        ST_ACCEPT: begin
          po_reject <= coin_bad | (sold_out_now & coin_any);
          if (cancel_go) begin
            ret_cnt   <= sum[CNT_W-1:0];
            po_credit <= '0;
            po_busy   <= 1'b1;
            state     <= ST_REFUND;
          end else if (vend_go) begin
            po_beverage <= 1'b1;
            po_credit   <= '0;
            if (change != '0) begin
              ret_cnt <= change[CNT_W-1:0];
              po_busy <= 1'b1;
              state   <= ST_CHANGE;
            end
          end else begin
            // A cancel with nothing to refund lands here with sum == 0,
            // which equals the (zero) credit, so it is a no-op.
            po_credit <= sum[CNT_W-1:0];
          end
        end
        default: begin
          // CHANGE and REFUND pay out identically. The pulse issued while the
          // counter holds 1 is the last one.
          po_money  <= 1'b1;
          po_reject <= coin_any;
          ret_cnt   <= ret_cnt - CNT_W'(1);
          if (ret_cnt <= CNT_W'(1)) begin
            po_busy <= 1'b0;
            state   <= ST_ACCEPT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
module tb_vending_machine_param;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       pi_money_half;
  logic       pi_money_one;
  logic       pi_cancel;
  logic       pi_restock;
  logic       po_beverage;
  logic       po_money;
  logic       po_reject;
  logic [3:0] po_credit;
  logic       po_busy;
  logic       po_sold_out;

  int n_cmp;
  int n_fail;

  vending_machine_param #(
    .PRICE      (3),
    .CNT_W      (4),
    .STOCK_INIT (1),
    .STOCK_W    (4)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .pi_money_half (pi_money_half),
    .pi_money_one  (pi_money_one),
    .pi_cancel     (pi_cancel),
    .pi_restock    (pi_restock),
    .po_beverage   (po_beverage),
    .po_money      (po_money),
    .po_reject     (po_reject),
    .po_credit     (po_credit),
    .po_busy       (po_busy),
    .po_sold_out   (po_sold_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic half_coin();
    pi_money_half = 1'b1;
    tick();
    pi_money_half = 1'b0;
  endtask

  task automatic one_coin();
    pi_money_one = 1'b1;
    tick();
    pi_money_one = 1'b0;
  endtask

  task automatic restock();
    pi_restock = 1'b1;
    tick();
    pi_restock = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    pi_money_half = 1'b1;
    tick();
    pi_money_half = 1'b0;
    n_cmp++; if (po_credit !== 4'd0) begin n_fail++; $display("FAIL rst_credit: got %0d want 0", po_credit); end
    n_cmp++; if ({po_beverage, po_money, po_reject, po_busy, po_sold_out} !== 5'b0) begin n_fail++; $display("FAIL rst_outputs: got %b want 00000", {po_beverage, po_money, po_reject, po_busy, po_sold_out}); end
    sys_rst_n = 1'b1;
    tick();
    n_cmp++; if (po_credit !== 4'd0) begin n_fail++; $display("FAIL rst_idle_credit: got %0d want 0", po_credit); end
  endtask

  task automatic test_half_coins();
    int pulses;
    restock();
    half_coin();
    n_cmp++; if (po_credit !== 4'd1) begin n_fail++; $display("FAIL half1_credit: got %0d want 1", po_credit); end
    half_coin();
    n_cmp++; if (po_credit !== 4'd2) begin n_fail++; $display("FAIL half2_credit: got %0d want 2", po_credit); end
    n_cmp++; if (po_beverage !== 1'b0) begin n_fail++; $display("FAIL half2_bev: got %b want 0", po_beverage); end
    half_coin();
    n_cmp++; if (po_beverage !== 1'b1) begin n_fail++; $display("FAIL half3_bev: got %b want 1", po_beverage); end
    n_cmp++; if (po_credit !== 4'd0) begin n_fail++; $display("FAIL half3_credit: got %0d want 0", po_credit); end
    n_cmp++; if (po_busy !== 1'b0) begin n_fail++; $display("FAIL half3_busy: got %b want 0", po_busy); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (po_money) pulses++;
      tick();
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL half_money_count: got %0d want 0", pulses); end
    n_cmp++; if (po_beverage !== 1'b0) begin n_fail++; $display("FAIL half_bev_one_cycle: got %b want 0", po_beverage); end
  endtask

  task automatic test_change();
    int pulses;
    restock();
    one_coin();
    n_cmp++; if (po_credit !== 4'd2) begin n_fail++; $display("FAIL chg_credit2: got %0d want 2", po_credit); end
    one_coin();
    n_cmp++; if (po_beverage !== 1'b1) begin n_fail++; $display("FAIL chg_bev: got %b want 1", po_beverage); end
    n_cmp++; if (po_money !== 1'b0) begin n_fail++; $display("FAIL chg_money_with_bev: got %b want 0", po_money); end
    n_cmp++; if (po_busy !== 1'b1) begin n_fail++; $display("FAIL chg_busy: got %b want 1", po_busy); end
    tick();
    n_cmp++; if (po_money !== 1'b1) begin n_fail++; $display("FAIL chg_money_first: got %b want 1", po_money); end
    n_cmp++; if (po_busy !== 1'b0) begin n_fail++; $display("FAIL chg_busy_end: got %b want 0", po_busy); end
    pulses = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (po_money) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL chg_money_count: got %0d want 1", pulses); end
    n_cmp++; if (po_credit !== 4'd0) begin n_fail++; $display("FAIL chg_credit_end: got %0d want 0", po_credit); end
  endtask

  task automatic test_cancel();
    int pulses;
    restock();
    pi_cancel = 1'b1;
    tick();
    pi_cancel = 1'b0;
    n_cmp++; if (po_busy !== 1'b0) begin n_fail++; $display("FAIL cancel_empty_busy: got %b want 0", po_busy); end
    tick();
    n_cmp++; if (po_money !== 1'b0) begin n_fail++; $display("FAIL cancel_empty_money: got %b want 0", po_money); end
    one_coin();
    pi_cancel = 1'b1;
    pi_money_one = 1'b1;
    tick();
    pi_cancel = 1'b0;
    pi_money_one = 1'b0;
    n_cmp++; if (po_beverage !== 1'b0) begin n_fail++; $display("FAIL cancel_bev: got %b want 0", po_beverage); end
    n_cmp++; if (po_credit !== 4'd0) begin n_fail++; $display("FAIL cancel_credit: got %0d want 0", po_credit); end
    n_cmp++; if (po_busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy: got %b want 1", po_busy); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (po_money) pulses++;
      if (i < 4 && po_money !== 1'b1) begin
        n_cmp++; n_fail++; $display("FAIL cancel_consecutive: pulse %0d got 0 want 1", i);
      end
    end
    n_cmp++; if (pulses !== 4) begin n_fail++; $display("FAIL cancel_money_count: got %0d want 4", pulses); end
    n_cmp++; if (po_busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy_end: got %b want 0", po_busy); end
  endtask

  task automatic test_reject();
    int pulses;
    restock();
    one_coin();
    one_coin();
    half_coin();
    n_cmp++; if (po_reject !== 1'b1) begin n_fail++; $display("FAIL rej_chg_reject: got %b want 1", po_reject); end
    pulses = po_money ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (po_money) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL rej_chg_count: got %0d want 1", pulses); end
    n_cmp++; if (po_credit !== 4'd0) begin n_fail++; $display("FAIL rej_chg_credit: got %0d want 0", po_credit); end
    one_coin();
    pi_cancel = 1'b1;
    tick();
    pi_cancel = 1'b0;
    one_coin();
    n_cmp++; if (po_reject !== 1'b1) begin n_fail++; $display("FAIL rej_ref_reject: got %b want 1", po_reject); end
    pulses = po_money ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (po_money) pulses++;
    end
    n_cmp++; if (pulses !== 2) begin n_fail++; $display("FAIL rej_ref_count: got %0d want 2", pulses); end
    n_cmp++; if (po_credit !== 4'd0) begin n_fail++; $display("FAIL rej_ref_credit: got %0d want 0", po_credit); end
    half_coin();
    pi_money_half = 1'b1;
    pi_money_one = 1'b1;
    tick();
    pi_money_half = 1'b0;
    pi_money_one = 1'b0;
    n_cmp++; if (po_reject !== 1'b1) begin n_fail++; $display("FAIL rej_both_reject: got %b want 1", po_reject); end
    n_cmp++; if (po_credit !== 4'd1) begin n_fail++; $display("FAIL rej_both_credit: got %0d want 1", po_credit); end
    pi_cancel = 1'b1;
    tick();
    pi_cancel = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_back_to_back();
    restock();
    one_coin();
    one_coin();
    tick();
    n_cmp++; if (po_money !== 1'b1) begin n_fail++; $display("FAIL b2b_last_pulse: got %b want 1", po_money); end
    half_coin();
    n_cmp++; if (po_credit !== 4'd1) begin n_fail++; $display("FAIL b2b_credit: got %0d want 1", po_credit); end
    n_cmp++; if (po_reject !== 1'b0) begin n_fail++; $display("FAIL b2b_reject: got %b want 0", po_reject); end
    pi_cancel = 1'b1;
    tick();
    pi_cancel = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_stock();
    restock();
    half_coin();
    half_coin();
    half_coin();
    n_cmp++; if (po_beverage !== 1'b1) begin n_fail++; $display("FAIL stk_vend1_bev: got %b want 1", po_beverage); end
`ifdef STOCK_COUNT_EN
    n_cmp++; if (po_sold_out !== 1'b1) begin n_fail++; $display("FAIL stk_sold_out: got %b want 1", po_sold_out); end
    half_coin();
    n_cmp++; if (po_reject !== 1'b1) begin n_fail++; $display("FAIL stk_coin_reject: got %b want 1", po_reject); end
    n_cmp++; if (po_credit !== 4'd0) begin n_fail++; $display("FAIL stk_coin_credit: got %0d want 0", po_credit); end
    restock();
    n_cmp++; if (po_sold_out !== 1'b0) begin n_fail++; $display("FAIL stk_restocked: got %b want 0", po_sold_out); end
    half_coin();
    half_coin();
    half_coin();
    n_cmp++; if (po_beverage !== 1'b1) begin n_fail++; $display("FAIL stk_vend2_bev: got %b want 1", po_beverage); end
`else
    n_cmp++; if (po_sold_out !== 1'b0) begin n_fail++; $display("FAIL stk_sold_out: got %b want 0", po_sold_out); end
    half_coin();
    n_cmp++; if (po_reject !== 1'b0) begin n_fail++; $display("FAIL stk_coin_reject: got %b want 0", po_reject); end
    n_cmp++; if (po_credit !== 4'd1) begin n_fail++; $display("FAIL stk_coin_credit: got %0d want 1", po_credit); end
    restock();
    n_cmp++; if (po_credit !== 4'd1) begin n_fail++; $display("FAIL stk_restock_credit: got %0d want 1", po_credit); end
    half_coin();
    half_coin();
    n_cmp++; if (po_beverage !== 1'b1) begin n_fail++; $display("FAIL stk_vend2_bev: got %b want 1", po_beverage); end
`endif
    tick();
  endtask

  task automatic test_reset_mid_refund();
    int pulses;
    restock();
    one_coin();
    pi_cancel = 1'b1;
    pi_money_one = 1'b1;
    tick();
    pi_cancel = 1'b0;
    pi_money_one = 1'b0;
    tick();
    tick();
    n_cmp++; if (po_money !== 1'b1) begin n_fail++; $display("FAIL mid_pulse2: got %b want 1", po_money); end
    #1 sys_rst_n = 1'b0;
    #1;
    n_cmp++; if ({po_money, po_busy, po_beverage, po_reject} !== 4'b0) begin n_fail++; $display("FAIL mid_async_outputs: got %b want 0000", {po_money, po_busy, po_beverage, po_reject}); end
    n_cmp++; if (po_credit !== 4'd0) begin n_fail++; $display("FAIL mid_async_credit: got %0d want 0", po_credit); end
    #1 sys_rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (po_money) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL mid_no_pulses: got %0d want 0", pulses); end
    half_coin();
    n_cmp++; if (po_credit !== 4'd1) begin n_fail++; $display("FAIL mid_accept_credit: got %0d want 1", po_credit); end
    n_cmp++; if (po_reject !== 1'b0) begin n_fail++; $display("FAIL mid_accept_reject: got %b want 0", po_reject); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    sys_rst_n = 1'b0;
    pi_money_half = 1'b0;
    pi_money_one = 1'b0;
    pi_cancel = 1'b0;
    pi_restock = 1'b0;
    test_reset();
    test_half_coins();
    test_change();
    test_cancel();
    test_reject();
    test_back_to_back();
    test_stock();
    test_reset_mid_refund();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
